mem_arbiter: RTL

Two-port arbiter that shares the core's single-port, one-cycle-latency word memory between the instruction-fetch port and the load/store port. It sits between the `candy` pipeline stages and the 4096-word memory. It grants at most one access per cycle, uses round-robin on conflict so neither side starves, and routes each read response back to its requester exactly one cycle after acceptance.

---
 rtl/mem_pkg.sv | 24 ++
 rtl/mem_arbiter_rr_arb2.sv | 40 ++++
 rtl/mem_arbiter.sv | 119 +++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types for the memory arbiter: memory geometry and the grant encoding
// used both for round-robin history and for response routing.
package mem_pkg;

    localparam int MEM_ADDR_W = 12;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_I    = 2'd1,
        GNT_D    = 2'd2
    } grant_t;

    // Expands a grant into {d, i} one-hot strobes.
    function automatic logic [1:0] grant_onehot(input grant_t g);
        logic [1:0] oh;
        case (g)
            GNT_I:   oh = 2'b01;
            GNT_D:   oh = 2'b10;
            default: oh = 2'b00;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; bit 0 is instruction fetch, bit 1 is data.
// On a conflict the requester not granted most recently wins.
module rr_arb2
    import mem_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);

    grant_t     last_grant_r;
    logic [1:0] gnt_s;

    // Grant history; reset to I so the first conflict goes to D.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            last_grant_r <= GNT_I;
        end else if (accept) begin
            last_grant_r <= gnt_s[1] ? GNT_D : GNT_I;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

    // One-hot grant selection from the current requests.
    always_comb begin
        gnt_s = 2'b00;
        case (req)
            2'b01:   gnt_s = 2'b01;
            2'b10:   gnt_s = 2'b10;
            2'b11:   gnt_s = (last_grant_r == GNT_D) ? 2'b01 : 2'b10;
            default: gnt_s = 2'b00;
        endcase
    end

    assign gnt = gnt_s;

endmodule

// File: rtl/mem_arbiter.sv
// Shares a single-port, one-cycle-latency word memory between the fetch port
// and the load/store port, routing each response back one cycle after grant.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_valid,
    input  logic [31:0]       i_addr,
    output logic              i_ready,
    output logic              i_rvalid,
    output logic [31:0]       i_rdata,
    input  logic              d_valid,
    input  logic [31:0]       d_addr,
    input  logic              d_we,
    input  logic [3:0]        d_wstrb,
    input  logic [31:0]       d_wdata,
    output logic              d_ready,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              m_en,
    output logic [3:0]        m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [31:0]       m_wdata,
    input  logic [31:0]       m_rdata,
    output logic [CNT_W-1:0]  conflict_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       gnt_s;
    logic             accept_s;
    grant_t           resp_sel_r;
    logic [CNT_W-1:0] conflict_cnt_r;
    logic             unused_addr_bits_s;

    rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .resetn (resetn),
        .req    ({d_valid, i_valid}),
        .accept (accept_s),
        .gnt    (gnt_s)
    );

    // Readies follow the grant but are held low while in reset.
    always_comb begin
        i_ready = 1'b0;
        d_ready = 1'b0;
        if (resetn) begin
            i_ready = gnt_s[0];
            d_ready = gnt_s[1];
        end else begin
            i_ready = 1'b0;
            d_ready = 1'b0;
        end
    end

    assign accept_s = i_ready | d_ready;
    assign m_en     = accept_s;

    // Memory request mux; everything reads zero when no access is issued.
    always_comb begin
        m_addr  = '0;
        m_we    = 4'b0000;
        m_wdata = 32'h0000_0000;
        if (d_ready) begin
            m_addr  = d_addr[ADDR_W+1:2];
            m_we    = d_we ? d_wstrb : 4'b0000;
            m_wdata = d_wdata;
        end else if (i_ready) begin
            m_addr  = i_addr[ADDR_W+1:2];
            m_we    = 4'b0000;
            m_wdata = d_wdata;
        end else begin
            m_addr  = '0;
            m_we    = 4'b0000;
            m_wdata = 32'h0000_0000;
        end
    end

    // Remembers which port owns the memory response arriving next cycle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            resp_sel_r <= GNT_NONE;
        end else if (d_ready) begin
            resp_sel_r <= GNT_D;
        end else if (i_ready) begin
            resp_sel_r <= GNT_I;
        end else begin
            resp_sel_r <= GNT_NONE;
        end
    end

    assign {d_rvalid, i_rvalid} = grant_onehot(resp_sel_r);
    assign i_rdata = m_rdata;
    assign d_rdata = m_rdata;

    // Saturating count of cycles in which both ports requested.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            conflict_cnt_r <= '0;
        end else if (i_valid && d_valid && (conflict_cnt_r != CNT_MAX)) begin
            conflict_cnt_r <= conflict_cnt_r + CNT_ONE;
        end else begin
            conflict_cnt_r <= conflict_cnt_r;
        end
    end

    assign conflict_cnt = conflict_cnt_r;

    // Byte-offset and out-of-range address bits are deliberately ignored.
    assign unused_addr_bits_s = ^{i_addr[31:ADDR_W+2], i_addr[1:0],
                                  d_addr[31:ADDR_W+2], d_addr[1:0]};

endmodule
